// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths, reset/enable polarities and line geometry helpers for the instruction
// fetch responder.
package inst_fetch_responder_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_DATA_W = 32;
   localparam logic        RST_ENABLE  = 1'b1;
   localparam logic        CHIP_ENABLE = 1'b1;

   // Word-offset field width for a line of line_words words.
   function automatic int unsigned off_width(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch-side and memory-side signals of the instruction fetch responder.
// The slave modport is the responder's view; master is the IF stage / memory view.
interface inst_fetch_responder_if
   import inst_fetch_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = INST_ADDR_W,
   parameter int unsigned DATA_W = INST_DATA_W
) ();

   logic              ce;
   logic [ADDR_W-1:0] pc;
   logic              inv;
   logic [DATA_W-1:0] inst;
   logic              inst_valid;
   logic              hold;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  ce, pc, inv, mem_ack, mem_rdata,
      output inst, inst_valid, hold, mem_req, mem_addr
   );

   modport master (
      output ce, pc, inv, mem_ack, mem_rdata,
      input  inst, inst_valid, hold, mem_req, mem_addr
   );

endinterface

// File: rtl/inst_line_buf.sv
// One-line instruction buffer: word array with a write port and combinational read port,
// plus the line valid flag and tag.
module inst_line_buf
   import inst_fetch_responder_pkg::*;
#(
   parameter int unsigned DATA_W     = INST_DATA_W,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned TAG_W      = 28
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [$clog2(LINE_WORDS)-1:0] waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [$clog2(LINE_WORDS)-1:0] raddr,
   output logic [DATA_W-1:0]             rdata,
   input  logic                          tag_load,
   input  logic [TAG_W-1:0]              tag_in,
   input  logic                          valid_clr,
   input  logic                          valid_set,
   output logic                          valid,
   output logic [TAG_W-1:0]              tag
);

   logic [DATA_W-1:0] words_q [LINE_WORDS];
   logic              valid_q;
   logic [TAG_W-1:0]  tag_q;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         for (int i = 0; i < int'(LINE_WORDS); i++) words_q[i] <= '0;
      end else if (we) begin
         words_q[waddr] <= wdata;
      end
   end

   // Loading a new tag always invalidates the line until its refill completes.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else if (tag_load) begin
         valid_q <= 1'b0;
         tag_q   <= tag_in;
      end else if (valid_clr) begin
         valid_q <= 1'b0;
      end else if (valid_set) begin
         valid_q <= 1'b1;
      end
   end

   assign rdata = words_q[raddr];
   assign valid = valid_q;
   assign tag   = tag_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// Serves IF-stage fetches from a one-line buffer; on a miss holds IF and refills the line
// word-by-word from a variable-latency memory over a req/ack handshake.
module inst_fetch_responder
   import inst_fetch_responder_pkg::*;
#(
   parameter int unsigned ADDR_W     = INST_ADDR_W,
   parameter int unsigned DATA_W     = INST_DATA_W,
   parameter int unsigned LINE_WORDS = 4
) (
   input logic                   clk,
   input logic                   rst,
   inst_fetch_responder_if.slave bus
);

   localparam int unsigned OFF_W = off_width(LINE_WORDS);
   localparam int unsigned TAG_W = ADDR_W - OFF_W - 2;

   typedef enum logic [0:0] {StIdle, StRefill} state_e;

   state_e           state_q, state_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic             inv_pending_q, inv_pending_d;

   logic [TAG_W-1:0]  tag, buf_tag;
   logic [OFF_W-1:0]  off;
   logic              fetch, hit, buf_valid;
   logic              lb_we, tag_load, valid_clr, valid_set;
   logic [DATA_W-1:0] lb_rdata;
   logic              unused_pc;

   assign tag       = bus.pc[ADDR_W-1:OFF_W+2];
   assign off       = bus.pc[OFF_W+1:2];
   assign unused_pc = ^bus.pc[1:0];
   assign fetch     = (bus.ce == CHIP_ENABLE);
   assign hit       = (state_q == StIdle) && fetch && buf_valid && (tag == buf_tag);

   inst_line_buf #(
      .DATA_W    (DATA_W),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
   ) u_line_buf (
      .clk      (clk),
      .rst      (rst),
      .we       (lb_we),
      .waddr    (cnt_q),
      .wdata    (bus.mem_rdata),
      .raddr    (off),
      .rdata    (lb_rdata),
      .tag_load (tag_load),
      .tag_in   (tag),
      .valid_clr(valid_clr),
      .valid_set(valid_set),
      .valid    (buf_valid),
      .tag      (buf_tag)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         inv_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         inv_pending_q <= inv_pending_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      inv_pending_d = inv_pending_q;
      lb_we         = 1'b0;
      tag_load      = 1'b0;
      valid_clr     = 1'b0;
      valid_set     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fetch && !hit) begin
               state_d       = StRefill;
               tag_load      = 1'b1;
               cnt_d         = '0;
               inv_pending_d = 1'b0;
            end else if (bus.inv) begin
               valid_clr = 1'b1;
            end
         end
         StRefill: begin
            // An invalidate cannot abort the refill; it only denies the line its valid bit.
            if (bus.inv) inv_pending_d = 1'b1;
            if (bus.mem_ack) begin
               lb_we = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                  state_d   = StIdle;
                  valid_set = !(inv_pending_q || bus.inv);
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.inst       = '0;
      bus.inst_valid = 1'b0;
      bus.hold       = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_addr   = '0;
      unique case (state_q)
         StIdle: begin
            bus.inst_valid = hit;
            bus.hold       = fetch && !hit;
            if (hit) bus.inst = lb_rdata;
         end
         StRefill: begin
            bus.hold     = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {buf_tag, cnt_q, 2'b00};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: directed scenarios plus randomized fetches
// checked against a line-level cache model and a delayed-ack memory model.
module tb_inst_fetch_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   inst_fetch_responder #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .LINE_WORDS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] salt;

   // Memory model state
   int          cpw = 1;
   bit          stray = 0;
   bit          req_seen = 0;
   int          wait_left = 0;
   logic [31:0] req_addr;
   bit          addr_unstable = 0;
   logic [31:0] acked_q[$];

   // Reference model: which line (pc >> 4) the buffer holds, if any
   bit          model_valid = 0;
   logic [27:0] model_line = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ salt;
   endfunction

   function automatic bit line_seq_ok(input logic [31:0] pc, input int reps);
      logic [31:0] base;
      base = {pc[31:4], 4'h0};
      if (acked_q.size() != 4 * reps) return 0;
      for (int i = 0; i < 4 * reps; i++)
         if (acked_q[i] !== base + 32'(4 * (i % 4))) return 0;
      return 1;
   endfunction

   // Memory responds once mem_req has been up for cpw cycles; then samples at negedge.
   task automatic settle();
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (bus.mem_req) begin
         if (req_seen && bus.mem_addr !== req_addr) addr_unstable = 1;
         if (!req_seen) begin
            req_seen  = 1;
            req_addr  = bus.mem_addr;
            wait_left = cpw - 1;
         end
         if (wait_left == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(req_addr);
            acked_q.push_back(req_addr);
            req_seen = 0;
         end else begin
            wait_left--;
         end
      end else begin
         req_seen = 0;
         if (stray) begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
         end
      end
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic run_fetch(input logic [31:0] pc, output int hold_cycles,
                            output logic [31:0] inst, output bit got_valid,
                            output bit proto_bad);
      hold_cycles   = 0;
      got_valid     = 0;
      proto_bad     = 0;
      inst          = '0;
      addr_unstable = 0;
      acked_q.delete();
      for (int c = 0; c < 200; c++) begin
         bus.ce = 1'b1;
         bus.pc = pc;
         settle();
         if (bus.inst_valid) begin
            got_valid = 1;
            inst      = bus.inst;
            if (bus.hold || bus.mem_req) proto_bad = 1;
            break;
         end
         if (!bus.hold || bus.inst !== 32'h0) proto_bad = 1;
         hold_cycles++;
         advance();
      end
      advance();
      bus.ce = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.ce        = 1'b0;
      bus.pc        = '0;
      bus.inv       = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      checks++;
      if (bus.inst !== 32'h0 || bus.inst_valid !== 1'b0 || bus.hold !== 1'b0) begin
         errors++;
         $display("FAIL reset_fetch_outs: inst=%0h valid=%0b hold=%0b required 0/0/0",
                  bus.inst, bus.inst_valid, bus.hold);
      end
      checks++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_outs: req=%0b addr=%0h required 0/0", bus.mem_req,
                  bus.mem_addr);
      end
      advance();
      model_valid = 0;
   endtask

   task automatic test_cold_miss();
      int hc; logic [31:0] got; bit v, pb;
      cpw = 1;
      run_fetch(32'h100, hc, got, v, pb);
      checks++;
      if (hc != 5) begin
         errors++; $display("FAIL cold_hold_cycles: got %0d required 5", hc);
      end
      checks++;
      if (!v || got !== mem_word(32'h100)) begin
         errors++;
         $display("FAIL cold_inst: valid=%0b inst=%0h required %0h", v, got, mem_word(32'h100));
      end
      checks++;
      if (!line_seq_ok(32'h100, 1)) begin
         errors++; $display("FAIL cold_mem_addr: %0d words fetched, required 0x100..0x10C",
                            acked_q.size());
      end
      checks++;
      if (pb) begin
         errors++; $display("FAIL cold_protocol: hold/inst/mem_req inconsistent, got 1 required 0");
      end
      model_valid = 1;
      model_line  = 28'h10;
   endtask

   task automatic test_hits();
      int hc; logic [31:0] got; bit v, pb;
      logic [31:0] pcs[3];
      pcs = '{32'h104, 32'h108, 32'h10C};
      for (int i = 0; i < 3; i++) begin
         run_fetch(pcs[i], hc, got, v, pb);
         checks++;
         if (hc != 0 || acked_q.size() != 0 || pb) begin
            errors++;
            $display("FAIL hit_stall pc=%0h: hold=%0d reqs=%0d required 0/0", pcs[i], hc,
                     acked_q.size());
         end
         checks++;
         if (!v || got !== mem_word(pcs[i])) begin
            errors++;
            $display("FAIL hit_inst pc=%0h: got %0h required %0h", pcs[i], got,
                     mem_word(pcs[i]));
         end
      end
   endtask

   task automatic test_slow_mem();
      int hc; logic [31:0] got; bit v, pb;
      cpw = 3;
      run_fetch(32'h208, hc, got, v, pb);
      checks++;
      if (hc != 13) begin
         errors++; $display("FAIL slow_hold_cycles: got %0d required 13", hc);
      end
      checks++;
      if (addr_unstable || !line_seq_ok(32'h208, 1)) begin
         errors++;
         $display("FAIL slow_mem_addr: unstable=%0b words=%0d required stable 0x200..0x20C",
                  addr_unstable, acked_q.size());
      end
      checks++;
      if (!v || got !== mem_word(32'h208) || pb) begin
         errors++;
         $display("FAIL slow_inst: got %0h required %0h", got, mem_word(32'h208));
      end
      cpw = 1;
      model_valid = 1;
      model_line  = 28'h20;
   endtask

   task automatic test_inv_refill();
      int hc; logic [31:0] got; bit v, inv_done;
      hc = 0; v = 0; got = '0; inv_done = 0;
      acked_q.delete();
      for (int c = 0; c < 200; c++) begin
         bus.ce  = 1'b1;
         bus.pc  = 32'h300;
         bus.inv = !inv_done && acked_q.size() == 1;
         if (bus.inv) inv_done = 1;
         settle();
         if (bus.inst_valid) begin
            v = 1; got = bus.inst;
            break;
         end
         hc++;
         advance();
      end
      bus.inv = 1'b0;
      advance();
      bus.ce = 1'b0;
      checks++;
      if (hc != 10) begin
         errors++; $display("FAIL inv_refill_hold_cycles: got %0d required 10", hc);
      end
      checks++;
      if (!line_seq_ok(32'h300, 2)) begin
         errors++;
         $display("FAIL inv_refill_refetch: %0d words fetched, required 0x300..0x30C twice",
                  acked_q.size());
      end
      checks++;
      if (!v || got !== mem_word(32'h300)) begin
         errors++; $display("FAIL inv_refill_inst: got %0h required %0h", got, mem_word(32'h300));
      end
      model_valid = 1;
      model_line  = 28'h30;
   endtask

   task automatic test_ce_low();
      int hc; logic [31:0] got; bit v, pb;
      stray = 1;
      for (int c = 0; c < 20; c++) begin
         bus.ce  = 1'b0;
         bus.pc  = $urandom;
         bus.inv = 1'b0;
         settle();
         checks++;
         if (bus.inst !== 32'h0 || bus.inst_valid || bus.hold || bus.mem_req) begin
            errors++;
            $display("FAIL ce_low_idle cyc=%0d: inst=%0h v=%0b hold=%0b req=%0b required 0",
                     c, bus.inst, bus.inst_valid, bus.hold, bus.mem_req);
         end
         advance();
      end
      stray = 0;
      bus.mem_ack = 1'b0;
      run_fetch(32'h304, hc, got, v, pb);
      checks++;
      if (hc != 0 || !v || got !== mem_word(32'h304)) begin
         errors++;
         $display("FAIL ce_low_buffer_kept: hold=%0d inst=%0h required 0/%0h", hc, got,
                  mem_word(32'h304));
      end
   endtask

   task automatic test_inv_idle();
      int hc; logic [31:0] got; bit v, pb;
      bus.ce  = 1'b1;
      bus.pc  = 32'h308;
      bus.inv = 1'b1;
      settle();
      checks++;
      if (!bus.inst_valid || bus.hold || bus.inst !== mem_word(32'h308)) begin
         errors++;
         $display("FAIL inv_idle_same_cycle_hit: v=%0b inst=%0h required 1/%0h",
                  bus.inst_valid, bus.inst, mem_word(32'h308));
      end
      advance();
      bus.inv = 1'b0;
      bus.ce  = 1'b0;
      run_fetch(32'h308, hc, got, v, pb);
      checks++;
      if (hc != 5 || !v || got !== mem_word(32'h308)) begin
         errors++;
         $display("FAIL inv_idle_next_miss: hold=%0d inst=%0h required 5/%0h", hc, got,
                  mem_word(32'h308));
      end
      model_valid = 1;
      model_line  = 28'h30;
   endtask

   task automatic test_rst_refill();
      int hc; logic [31:0] got; bit v, pb;
      cpw = 1;
      acked_q.delete();
      for (int c = 0; c < 50 && acked_q.size() < 2; c++) begin
         bus.ce = 1'b1;
         bus.pc = 32'h500;
         settle();
         advance();
      end
      rst = 1'b1;
      settle();
      advance();
      rst    = 1'b0;
      bus.ce = 1'b0;
      settle();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.hold !== 1'b0) begin
         errors++;
         $display("FAIL rst_refill_drop: req=%0b hold=%0b required 0/0", bus.mem_req, bus.hold);
      end
      advance();
      model_valid = 0;
      run_fetch(32'h500, hc, got, v, pb);
      checks++;
      if (hc != 5 || !line_seq_ok(32'h500, 1) || !v || got !== mem_word(32'h500)) begin
         errors++;
         $display("FAIL rst_refill_remiss: hold=%0d inst=%0h required 5/%0h", hc, got,
                  mem_word(32'h500));
      end
      model_valid = 1;
      model_line  = 28'h50;
   endtask

   task automatic test_random();
      int hc; logic [31:0] got; bit v, pb, hit;
      logic [31:0] lines[5];
      logic [31:0] pc;
      lines = '{32'h100, 32'h200, 32'h300, 32'h8000_0300, 32'h500};
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.ce  = 1'b0;
            bus.inv = 1'b1;
            settle();
            advance();
            bus.inv     = 1'b0;
            model_valid = 0;
         end
         pc  = lines[$urandom_range(0, 4)] | 32'($urandom_range(0, 15));
         cpw = $urandom_range(1, 3);
         hit = model_valid && (pc[31:4] == model_line);
         run_fetch(pc, hc, got, v, pb);
         checks++;
         if (hc != (hit ? 0 : 1 + 4 * cpw) || pb || addr_unstable) begin
            errors++;
            $display("FAIL rand_stall n=%0d pc=%0h: hold=%0d required %0d", n, pc, hc,
                     hit ? 0 : 1 + 4 * cpw);
         end
         checks++;
         if (!v || got !== mem_word(pc) || (hit ? acked_q.size() != 0 : !line_seq_ok(pc, 1)))
         begin
            errors++;
            $display("FAIL rand_data n=%0d pc=%0h: inst=%0h required %0h reqs=%0d", n, pc, got,
                     mem_word(pc), acked_q.size());
         end
         model_valid = 1;
         model_line  = pc[31:4];
      end
      cpw = 1;
   endtask

   initial begin
      salt = $urandom;
      test_reset();
      test_cold_miss();
      test_hits();
      test_slow_mem();
      test_inv_refill();
      test_ce_low();
      test_inv_idle();
      test_rst_refill();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
